fpu_mul_post: RTL and testbench

FPU_MUL_POST -- requirements
Module: fpu_mul_post

---
 rtl/fpu_mul_post_if.sv | 30 +++
 rtl/fpu_mul_post.sv | 204 ++++++++++++++++++++
 tb/tb_fpu_mul_post.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mul_post_if.sv
// fpu_mul_post_if -- issue/result bus of the single-precision multiply post-processor.
//   start        : operation issue strobe, qualifies opa/opb/rmode
//   opa, opb     : IEEE-754 single operands
//   rmode        : rounding mode (00 nearest-even, 01 zero, 10 +inf, 11 -inf)
//   out          : rounded result, valid while done=1 and held afterwards
//   done         : one-cycle result strobe
//   ovf/unf/ine/inv : overflow, underflow, inexact, invalid flags
// master drives the issue side (testbench / requester), slave is the post-processor.
interface fpu_mul_post_if;
    logic        start;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [1:0]  rmode;
    logic [31:0] out;
    logic        done;
    logic        ovf;
    logic        unf;
    logic        ine;
    logic        inv;

    modport master (
        output start, opa, opb, rmode,
        input  out, done, ovf, unf, ine, inv
    );

    modport slave (
        input  start, opa, opb, rmode,
        output out, done, ovf, unf, ine, inv
    );
endinterface

// File: rtl/fpu_mul_post.sv
// fpu_mul_post -- front/back end wrapped around an external LAT-cycle 24x24 multiplier.
// Decodes the operands, feeds the mantissas to the multiplier, carries sign, exponent sum,
// rounding mode and special-case class alongside it, then normalises, rounds and flags the
// product when it comes back.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : issue/result bus (slave side), see fpu_mul_post_if
//   mul_a, mul_b : combinational mantissas to the multiplier ({1,frac} or 0)
//   prod         : multiplier product, valid LAT cycles after the matching start
module fpu_mul_post #(
    parameter int unsigned LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_mul_post_if.slave bus,
    output logic [23:0]   mul_a,
    output logic [23:0]   mul_b,
    input  logic [47:0]   prod
);

    typedef enum logic [2:0] {
        ClsNorm,
        ClsZero,
        ClsInf,
        ClsNan,
        ClsNanInv
    } cls_e;

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [9:0] esum;   // two's complement ea+eb-127
        logic [1:0] rmode;
        cls_e       cls;
    } side_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ---------------- operand decode ----------------
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign ea = bus.opa[30:23];
    assign eb = bus.opb[30:23];
    assign fa = bus.opa[22:0];
    assign fb = bus.opb[22:0];

    // Denormals count as zero.
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_snan = a_nan && !fa[22];
    assign b_snan = b_nan && !fb[22];

    assign mul_a = (a_zero || ea == 8'hFF) ? 24'd0 : {1'b1, fa};
    assign mul_b = (b_zero || eb == 8'hFF) ? 24'd0 : {1'b1, fb};

    side_t side_in;

    always_comb begin
        side_in       = '0;
        side_in.valid = bus.start;
        side_in.sign  = bus.opa[31] ^ bus.opb[31];
        side_in.esum  = {2'b00, ea} + {2'b00, eb} - 10'd127;
        side_in.rmode = bus.rmode;
        if (a_nan || b_nan) begin
            side_in.cls = (a_snan || b_snan) ? ClsNanInv : ClsNan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            side_in.cls = ClsNanInv;
        end else if (a_inf || b_inf) begin
            side_in.cls = ClsInf;
        end else if (a_zero || b_zero) begin
            side_in.cls = ClsZero;
        end else begin
            side_in.cls = ClsNorm;
        end
    end

    // ---------------- side-band pipeline, matches multiplier depth ----------------
    side_t pipe_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= side_in;
            for (int i = 1; i < int'(LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    side_t tail;
    assign tail = pipe_q[LAT-1];

    // ---------------- normalise, round, classify ----------------
    logic               hi, guard, sticky, inexact, inc;
    logic [22:0]        mant;
    logic [23:0]        mant_rnd;
    logic signed [10:0] exp_fin;
    logic [31:0]        inf_res, max_res, res;
    logic               res_ovf, res_unf, res_ine, res_inv;

    always_comb begin
        hi      = prod[47];
        mant    = hi ? prod[46:24] : prod[45:23];
        guard   = hi ? prod[23] : prod[22];
        sticky  = hi ? (|prod[22:0]) : (|prod[21:0]);
        inexact = guard | sticky;

        case (tail.rmode)
            2'b00:   inc = guard & (sticky | mant[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~tail.sign & inexact;
            default: inc = tail.sign & inexact;
        endcase

        // A carry out of the 23-bit mantissa leaves mant_rnd[22:0] at zero already.
        mant_rnd = {1'b0, mant} + {23'd0, inc};
        exp_fin  = $signed({tail.esum[9], tail.esum}) + $signed({10'd0, hi})
                 + $signed({10'd0, mant_rnd[23]});

        inf_res = {tail.sign, 8'hFF, 23'd0};
        max_res = {tail.sign, 8'hFE, 23'h7F_FFFF};

        res     = '0;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_ine = 1'b0;
        res_inv = 1'b0;

        case (tail.cls)
            ClsNan: begin
                res = QNAN;
            end
            ClsNanInv: begin
                res     = QNAN;
                res_inv = 1'b1;
            end
            ClsInf: begin
                res = inf_res;
            end
            ClsZero: begin
                res = {tail.sign, 31'd0};
            end
            default: begin
                if (exp_fin >= 11'sd255) begin
                    res_ovf = 1'b1;
                    res_ine = 1'b1;
                    case (tail.rmode)
                        2'b00:   res = inf_res;
                        2'b01:   res = max_res;
                        2'b10:   res = tail.sign ? max_res : inf_res;
                        default: res = tail.sign ? inf_res : max_res;
                    endcase
                end else if (exp_fin <= 11'sd0) begin
                    res_unf = 1'b1;
                    res_ine = 1'b1;
                    res     = {tail.sign, 31'd0};
                end else begin
                    res_ine = inexact;
                    res     = {tail.sign, exp_fin[7:0], mant_rnd[22:0]};
                end
            end
        endcase
    end

    // ---------------- result registers, held between done pulses ----------------
    logic [31:0] out_q;
    logic        done_q, ovf_q, unf_q, ine_q, inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            ine_q  <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            done_q <= tail.valid;
            if (tail.valid) begin
                out_q <= res;
                ovf_q <= res_ovf;
                unf_q <= res_unf;
                ine_q <= res_ine;
                inv_q <= res_inv;
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;
    assign bus.ine  = ine_q;
    assign bus.inv  = inv_q;

endmodule

// File: tb/tb_fpu_mul_post.sv
// tb_fpu_mul_post -- self-checking bench for fpu_mul_post with an ideal LAT-stage multiplier.
module tb_fpu_mul_post;

    localparam int unsigned LAT  = 3;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] mul_a, mul_b;
    logic [47:0] prod;

    fpu_mul_post_if bus ();

    fpu_mul_post #(.LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .prod  (prod)
    );

    always #5 clk = ~clk;

    // External pipelined multiplier.
    logic [47:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= 48'(mul_a) * 48'(mul_b);
        for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
    end
    assign prod = mpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  flags;   // {ovf, unf, ine, inv}
        int          cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t res_q[$];

    always @(negedge clk) begin
        if (bus.done) res_q.push_back('{bus.out, {bus.ovf, bus.unf, bus.ine, bus.inv}, cyc});
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: exact integer product of the significands, rounded by remainder comparison.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        logic            sign, ovf, unf, ine, up;
        int              ea, eb, e, s;
        bit              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned ma, mb, p, q, r, half;
        logic [31:0]     res, inf_v, max_v;
        sign   = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {3'b000, a_snan || b_snan, QNAN};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b0001, QNAN};
        if (a_inf || b_inf) return {4'b0000, sign, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {4'b0000, sign, 31'd0};
        ma = (64'd1 << 23) | 64'(a[22:0]);
        mb = (64'd1 << 23) | 64'(b[22:0]);
        p  = ma * mb;
        if (p >= (64'd1 << 47)) begin
            s = 24;
            e = ea + eb - 126;
        end else begin
            s = 23;
            e = ea + eb - 127;
        end
        q    = p >> s;
        r    = p - (q << s);
        half = 64'd1 << (s - 1);
        ine  = (r != 0);
        case (rm)
            2'b00:   up = (r > half) || ((r == half) && q[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !sign && ine;
            default: up = sign && ine;
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        ovf   = 1'b0;
        unf   = 1'b0;
        inf_v = {sign, 8'hFF, 23'd0};
        max_v = {sign, 8'hFE, 23'h7F_FFFF};
        if (e >= 255) begin
            ovf = 1'b1;
            ine = 1'b1;
            case (rm)
                2'b00:   res = inf_v;
                2'b01:   res = max_v;
                2'b10:   res = sign ? max_v : inf_v;
                default: res = sign ? inf_v : max_v;
            endcase
        end else if (e <= 0) begin
            unf = 1'b1;
            ine = 1'b1;
            res = {sign, 31'd0};
        end else begin
            res = {sign, 8'(e), q[22:0]};
        end
        return {ovf, unf, ine, 1'b0, res};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [22:0] f;
        logic        s;
        int          k;
        f = 23'($urandom);
        s = 1'($urandom);
        k = $urandom_range(0, 15);
        case (k)
            0:       return {s, 8'd0, 23'd0};
            1:       return {s, 8'd0, f};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, 1'b1, f[21:0]};
            4:       return {s, 8'hFF, 1'b0, f[21:0] | 22'd1};
            5, 6:    return {s, 8'($urandom_range(200, 254)), f};
            7, 8:    return {s, 8'($urandom_range(1, 60)), f};
            default: return {s, 8'($urandom_range(100, 154)), f};
        endcase
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        logic [35:0] r;
        @(negedge clk);
        bus.start = 1'b1;
        bus.opa   = a;
        bus.opb   = b;
        bus.rmode = rm;
        r = ref_mul(a, b, rm);
        exp_q.push_back('{r[31:0], r[35:32], cyc});
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        for (int i = 0; i < 40 + 4 * n && res_q.size() < n; i++) @(negedge clk);
        ok = (res_q.size() >= n);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.opa   = '0;
        bus.opb   = '0;
        bus.rmode = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.done, bus.ovf, bus.unf, bus.ine, bus.inv} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.done, bus.ovf, bus.unf, bus.ine, bus.inv});
        else n_pass++;
        n_checks++;
        if (bus.out !== 32'h0) $display("FAIL reset_out: got %h want 00000000", bus.out);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.out !== 32'h0)
            $display("FAIL post_reset_idle: got done=%b out=%h want 0/00000000", bus.done, bus.out);
        else n_pass++;
    endtask

    task automatic test_mantissa();
        logic [31:0] ops [8];
        logic [23:0] sig [8];
        ops = '{32'h3F80_0000, 32'h3FC0_0000, 32'h0000_0000, 32'h0040_0000,
                32'h7F80_0000, 32'h7FC0_0000, 32'h7F7F_FFFF, 32'h8080_0000};
        sig = '{24'h80_0000, 24'hC0_0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFF_FFFF, 24'h80_0000};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.opa = ops[i];
            bus.opb = ops[7-i];
            #1;
            n_checks++;
            if (mul_a !== sig[i]) $display("FAIL mul_a[%0d]: got %h want %h", i, mul_a, sig[i]);
            else n_pass++;
            n_checks++;
            if (mul_b !== sig[7-i])
                $display("FAIL mul_b[%0d]: got %h want %h", i, mul_b, sig[7-i]);
            else n_pass++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] out;
        logic [3:0]  flags;
    } vec_t;

    task automatic test_directed();
        vec_t v [16];
        bit   ok;
        rec_t got;
        v = '{
            '{32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h3F80_0000, 4'b0000},
            '{32'h3FC0_0000, 32'h3FC0_0000, 2'b00, 32'h4010_0000, 4'b0000},
            '{32'h3F80_0001, 32'h3F80_0001, 2'b00, 32'h3F80_0002, 4'b0010},
            '{32'h3F80_0001, 32'h3F80_0001, 2'b01, 32'h3F80_0002, 4'b0010},
            '{32'h3F80_0001, 32'h3F80_0001, 2'b10, 32'h3F80_0003, 4'b0010},
            '{32'h7F00_0000, 32'h7F00_0000, 2'b00, 32'h7F80_0000, 4'b1010},
            '{32'h7F00_0000, 32'h7F00_0000, 2'b01, 32'h7F7F_FFFF, 4'b1010},
            '{32'hFF00_0000, 32'h7F00_0000, 2'b10, 32'hFF7F_FFFF, 4'b1010},
            '{32'hFF00_0000, 32'h7F00_0000, 2'b11, 32'hFF80_0000, 4'b1010},
            '{32'h7F00_0000, 32'h7F00_0000, 2'b11, 32'h7F7F_FFFF, 4'b1010},
            '{32'h0080_0000, 32'h3F00_0000, 2'b00, 32'h0000_0000, 4'b0110},
            '{32'h7F80_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000, 4'b0001},
            '{32'h7F80_0000, 32'hC000_0000, 2'b00, 32'hFF80_0000, 4'b0000},
            '{32'h8000_0000, 32'h3F80_0000, 2'b00, 32'h8000_0000, 4'b0000},
            '{32'h7F80_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 4'b0001},
            '{32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 4'b0000}
        };
        for (int i = 0; i < 16; i++) begin
            res_q.delete();
            exp_q.delete();
            issue(v[i].a, v[i].b, v[i].rm);
            idle();
            wait_results(1, ok);
            n_checks++;
            if (!ok) begin
                $display("FAIL dir[%0d]_timeout: got no done want done", i);
                continue;
            end
            n_pass++;
            got = res_q.pop_front();
            n_checks++;
            if (got.out !== v[i].out)
                $display("FAIL dir[%0d]_out: got %h want %h", i, got.out, v[i].out);
            else n_pass++;
            n_checks++;
            if (got.flags !== v[i].flags)
                $display("FAIL dir[%0d]_flags: got %b want %b", i, got.flags, v[i].flags);
            else n_pass++;
            n_checks++;
            if (got.cyc - exp_q[0].cyc != int'(LAT) + 1)
                $display("FAIL dir[%0d]_latency: got %0d want %0d", i,
                         got.cyc - exp_q[0].cyc, LAT + 1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit   ok;
        rec_t got, want;
        int   n;
        res_q.delete();
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            issue(rand_op(), rand_op(), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        n = exp_q.size();
        wait_results(n, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (res_q.size() != n) $display("FAIL rand_count: got %0d want %0d", res_q.size(), n);
        else n_pass++;
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            got  = res_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got.out !== want.out || got.flags !== want.flags)
                $display("FAIL rand_result: got %h/%b want %h/%b", got.out, got.flags,
                         want.out, want.flags);
            else n_pass++;
            n_checks++;
            if (got.cyc - want.cyc != int'(LAT) + 1)
                $display("FAIL rand_latency: got %0d want %0d", got.cyc - want.cyc, LAT + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        rec_t got [4];
        res_q.delete();
        exp_q.delete();
        issue(32'h3F80_0000, 32'h3F80_0000, 2'b00);
        issue(32'h3FC0_0000, 32'h3FC0_0000, 2'b00);
        issue(32'h4000_0000, 32'hC040_0000, 2'b01);
        issue(32'h3F80_0001, 32'h3F80_0001, 2'b10);
        idle();
        wait_results(4, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL b2b_count: got %0d want 4", res_q.size());
            return;
        end
        n_pass++;
        for (int i = 0; i < 4; i++) got[i] = res_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i].out !== exp_q[i].out || got[i].flags !== exp_q[i].flags)
                $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", i, got[i].out,
                         got[i].flags, exp_q[i].out, exp_q[i].flags);
            else n_pass++;
            n_checks++;
            if (got[i].cyc != exp_q[0].cyc + int'(LAT) + 1 + i)
                $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, got[i].cyc,
                         exp_q[0].cyc + int'(LAT) + 1 + i);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        res_q.delete();
        exp_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.opa   = 32'h3F80_0000;
        bus.opb   = 32'h3F80_0000;
        bus.rmode = 2'b00;
        @(negedge clk);
        bus.opa = 32'h3FC0_0000;
        bus.opb = 32'h3FC0_0000;
        @(negedge clk);
        rst_n   = 1'b0;
        bus.opa = 32'h4000_0000;
        @(negedge clk);
        bus.opa = 32'h4040_0000;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        n_checks++;
        if (res_q.size() != 0) $display("FAIL midrst_done: got %0d pulses want 0", res_q.size());
        else n_pass++;
        n_checks++;
        if (bus.out !== 32'h0 || {bus.ovf, bus.unf, bus.ine, bus.inv} !== 4'b0)
            $display("FAIL midrst_out: got %h/%b want 00000000/0000", bus.out,
                     {bus.ovf, bus.unf, bus.ine, bus.inv});
        else n_pass++;
    endtask

    task automatic test_start_after_reset();
        bit   ok;
        rec_t got;
        res_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.opa   = 32'h3FC0_0000;
        bus.opb   = 32'h3FC0_0000;
        bus.rmode = 2'b00;
        exp_q.push_back('{32'h4010_0000, 4'b0000, cyc});
        idle();
        wait_results(1, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL first_start_timeout: got no done want done");
            return;
        end
        n_pass++;
        got = res_q.pop_front();
        n_checks++;
        if (got.out !== 32'h4010_0000 || got.flags !== 4'b0)
            $display("FAIL first_start_result: got %h/%b want 40100000/0000", got.out, got.flags);
        else n_pass++;
        n_checks++;
        if (got.cyc - exp_q[0].cyc != int'(LAT) + 1)
            $display("FAIL first_start_latency: got %0d want %0d", got.cyc - exp_q[0].cyc,
                     LAT + 1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mantissa();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        test_start_after_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
